spi_slave_fl: RTL and testbench

//  SPI flash-target responder: the far end of the flash SPI master. Decodes command/address/dummy,

---
 rtl/spi_slave_fl_pkg.sv | 50 +++++
 rtl/spi_slave_fl_sync.sv | 56 +++++
 rtl/spi_slave_fl.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_spi_slave_fl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_fl_pkg.sv
// Shared definitions for the SPI flash target: opcodes, FSM states, lane modes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spi_slave_fl_pkg;

  // Flash opcodes understood by the target.
  localparam logic [7:0] OP_READ = 8'h03;  // read 1-1-1, no dummy
  localparam logic [7:0] OP_FAST = 8'h0B;  // fast read 1-1-1, cfg dummies
  localparam logic [7:0] OP_DUAL = 8'h3B;  // read 1-1-2, cfg dummies
  localparam logic [7:0] OP_QUAD = 8'h6B;  // read 1-1-4, cfg dummies
  localparam logic [7:0] OP_PP   = 8'h02;  // page program
  localparam logic [7:0] OP_RDID = 8'h9F;  // JEDEC id
  localparam logic [7:0] OP_EN4B = 8'hB7;  // enter 4-byte addressing
  localparam logic [7:0] OP_EX4B = 8'hE9;  // exit 4-byte addressing

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_t;

  typedef enum logic [1:0] {
    LANE_1 = 2'd0,  // data on DQ1
    LANE_2 = 2'd1,  // data on DQ1:0
    LANE_4 = 2'd2   // data on DQ3:0
  } lane_t;

  // Output-enable mask for a lane mode.
  function automatic logic [3:0] lane_oe(input lane_t l);
    case (l)
      LANE_1:  lane_oe = 4'b0010;
      LANE_2:  lane_oe = 4'b0011;
      default: lane_oe = 4'b1111;
    endcase
  endfunction

  // Bits moved per sclk fall for a lane mode.
  function automatic logic [2:0] lane_step(input lane_t l);
    case (l)
      LANE_1:  lane_step = 3'd1;
      LANE_2:  lane_step = 3'd2;
      default: lane_step = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/spi_slave_fl_sync.sv
// Synchroniser for the SPI pads: 2-flop sync of sclk/ss_n/dq_i plus edge pulses.
// Latency: 2 clk from pad to synced level, edge pulses valid in the 3rd clk.
// Backpressure: none; pulses are single-cycle and must be consumed when seen.
//
// Ports: sclk/ss_n/dq_i async pads in; sclk_rise/sclk_fall/ss_fall/ss_rise
// one-clk pulses; ss_n_s synced chip select; dq_s synced data lanes.
module spi_slave_fl_sync #(
  parameter bit CPOL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ss_n,
  input  logic [3:0] dq_i,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       ss_fall,
  output logic       ss_rise,
  output logic       ss_n_s,
  output logic [3:0] dq_s
);

  logic       sclk_m, sclk_s, sclk_d;
  logic       ss_m, ss_d;
  logic [3:0] dq_m;

  // Reset to the idle pad levels so leaving reset produces no false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_m <= CPOL;
      sclk_s <= CPOL;
      sclk_d <= CPOL;
      ss_m   <= 1'b1;
      ss_n_s <= 1'b1;
      ss_d   <= 1'b1;
      dq_m   <= 4'h0;
      dq_s   <= 4'h0;
    end else begin
      sclk_m <= sclk;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      ss_m   <= ss_n;
      ss_n_s <= ss_m;
      ss_d   <= ss_n_s;
      dq_m   <= dq_i;
      dq_s   <= dq_m;
    end
  end

  // dq_s has the same pipeline depth as sclk_s, so it is sampled in step with rise.
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_n_s & ss_d;
  assign ss_rise   = ss_n_s & ~ss_d;

endmodule

// File: rtl/spi_slave_fl.sv
// SPI flash target: decodes cmd/addr/dummy, serves reads on 1/2/4 lanes, packs program bytes.
// Latency: read word fetched on last addr rise, first bit driven on the following sclk fall.
// Backpressure: none; backend must answer mem_ren with mem_rdata exactly 1 clk later.
//
// Ports: clk/rst (async active-high); sclk, ss_n, dq_i pads in; dq_o/dq_oe pad drive;
// cfg_dummy dummy clocks for fast reads; mem_addr/mem_ren/mem_rdata word read port;
// mem_we/mem_wdata/mem_wstrb word write port; busy high while a frame is in progress.
module spi_slave_fl
  import spi_slave_fl_pkg::*;
#(
  parameter bit          CPOL      = 1'b1,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4018,
  parameter bit          ADDR4_DEF = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        ss_n,
  input  logic [3:0]  dq_i,
  output logic [3:0]  dq_o,
  output logic [3:0]  dq_oe,
  input  logic [3:0]  cfg_dummy,
  output logic [31:0] mem_addr,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        busy
);

  logic       sclk_rise, sclk_fall, ss_fall, ss_rise, ss_n_s;
  logic [3:0] dq_s;

  spi_slave_fl_sync #(.CPOL(CPOL)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .ss_n     (ss_n),
    .dq_i     (dq_i),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .ss_fall  (ss_fall),
    .ss_rise  (ss_rise),
    .ss_n_s   (ss_n_s),
    .dq_s     (dq_s)
  );

  // Only DQ0 is ever sampled; upper lanes are output-only in every supported mode.
  logic unused_dq;
  assign unused_dq = ^dq_s[3:1];

  state_t      state, state_nx;
  logic [5:0]  bit_cnt;
  logic [6:0]  sh;
  logic [30:0] addr_sh;
  logic        addr4, addr4_set_p, addr4_clr_p;
  lane_t       lane;
  logic        jedec, is_wr;
  logic [3:0]  dummy_n;
  logic [31:0] word_addr, cur_word, next_word;
  logic [1:0]  bptr, jidx;
  logic [2:0]  pos;
  logic        ren_cur, ren_cur_q, ren_nxt, ren_nxt_q;
  logic [31:0] wr_word;
  logic [3:0]  wr_strb;
  logic        flush_p;

  // SPI edges only count while selected.
  logic        rise, fall;
  logic [7:0]  cmd_byte;
  logic [31:0] addr_full;
  logic        addr_last, dummy_last, byte_end;
  logic [2:0]  step;
  logic [7:0]  jedec_byte, rd_byte, byte_sh;
  logic [3:0]  lane_bits;
  logic [31:0] wr_word_nx;
  logic [3:0]  wr_strb_nx;

  assign rise       = sclk_rise & ~ss_n_s;
  assign fall       = sclk_fall & ~ss_n_s;
  assign cmd_byte   = {sh, dq_s[0]};
  assign addr_full  = {addr_sh, dq_s[0]};
  assign addr_last  = (bit_cnt == (addr4 ? 6'd31 : 6'd23));
  assign dummy_last = ({2'b00, dummy_n} == bit_cnt + 6'd1);
  assign step       = lane_step(lane);
  assign byte_end   = ({1'b0, pos} + {1'b0, step}) == 4'd8;
  assign busy       = (state != ST_IDLE);

  always_comb begin
    jedec_byte = JEDEC_ID[7:0];
    case (jidx)
      2'd0:    jedec_byte = JEDEC_ID[23:16];
      2'd1:    jedec_byte = JEDEC_ID[15:8];
      default: jedec_byte = JEDEC_ID[7:0];
    endcase
    rd_byte = jedec ? jedec_byte : cur_word[{bptr, 3'b000} +: 8];
    // Left-align the bits not yet sent; the lane mapping takes them from the top.
    byte_sh = rd_byte << pos;
    case (lane)
      LANE_1:  lane_bits = {2'b00, byte_sh[7], 1'b0};
      LANE_2:  lane_bits = {2'b00, byte_sh[7:6]};
      default: lane_bits = byte_sh[7:4];
    endcase
    wr_word_nx = wr_word;
    wr_word_nx[{bptr, 3'b000} +: 8] = cmd_byte;
    wr_strb_nx = wr_strb | (4'b0001 << bptr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (ss_fall) state_nx = ST_CMD;
      ST_CMD: begin
        if (rise && bit_cnt == 6'd7) begin
          case (cmd_byte)
            OP_READ, OP_FAST, OP_DUAL, OP_QUAD, OP_PP: state_nx = ST_ADDR;
            OP_RDID: state_nx = ST_RDATA;
            default: state_nx = ST_IGNORE;
          endcase
        end
      end
      ST_ADDR: begin
        if (rise && addr_last) begin
          if (is_wr)              state_nx = ST_WDATA;
          else if (dummy_n != 0)  state_nx = ST_DUMMY;
          else                    state_nx = ST_RDATA;
        end
      end
      ST_DUMMY: if (rise && dummy_last) state_nx = ST_RDATA;
      default: ;
    endcase
    // Deselect aborts from any state.
    if (ss_rise) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_o        <= 4'h0;
      dq_oe       <= 4'h0;
      mem_addr    <= 32'h0;
      mem_ren     <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= 32'h0;
      mem_wstrb   <= 4'h0;
      bit_cnt     <= 6'd0;
      sh          <= 7'h0;
      addr_sh     <= 31'h0;
      addr4       <= ADDR4_DEF;
      addr4_set_p <= 1'b0;
      addr4_clr_p <= 1'b0;
      lane        <= LANE_1;
      jedec       <= 1'b0;
      is_wr       <= 1'b0;
      dummy_n     <= 4'h0;
      word_addr   <= 32'h0;
      cur_word    <= 32'h0;
      next_word   <= 32'h0;
      bptr        <= 2'd0;
      jidx        <= 2'd0;
      pos         <= 3'd0;
      ren_cur     <= 1'b0;
      ren_cur_q   <= 1'b0;
      ren_nxt     <= 1'b0;
      ren_nxt_q   <= 1'b0;
      wr_word     <= 32'h0;
      wr_strb     <= 4'h0;
      flush_p     <= 1'b0;
    end else begin
      mem_ren   <= 1'b0;
      mem_we    <= 1'b0;
      ren_cur   <= 1'b0;
      ren_nxt   <= 1'b0;
      flush_p   <= 1'b0;
      // Backend data is valid the clk after the backend saw mem_ren.
      ren_cur_q <= ren_cur;
      ren_nxt_q <= ren_nxt;
      if (ren_cur_q) cur_word  <= mem_rdata;
      if (ren_nxt_q) next_word <= mem_rdata;

      // Partial-word flush runs one clk after deselect, in IDLE, where no read can issue.
      if (flush_p) begin
        mem_we    <= 1'b1;
        mem_wdata <= wr_word;
        mem_wstrb <= wr_strb;
        mem_addr  <= word_addr;
        wr_word   <= 32'h0;
        wr_strb   <= 4'h0;
      end

      if (ss_rise) begin
        dq_oe <= 4'h0;
        dq_o  <= 4'h0;
        if (addr4_set_p)      addr4 <= 1'b1;
        else if (addr4_clr_p) addr4 <= 1'b0;
        addr4_set_p <= 1'b0;
        addr4_clr_p <= 1'b0;
        if (state == ST_WDATA && wr_strb != 4'h0) flush_p <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ss_fall) bit_cnt <= 6'd0;
          end
          ST_CMD: begin
            if (rise) begin
              sh      <= cmd_byte[6:0];
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd7) begin
                bit_cnt <= 6'd0;
                addr_sh <= 31'h0;
                dummy_n <= 4'h0;
                lane    <= LANE_1;
                jedec   <= 1'b0;
                is_wr   <= 1'b0;
                pos     <= 3'd0;
                jidx    <= 2'd0;
                wr_word <= 32'h0;
                wr_strb <= 4'h0;
                case (cmd_byte)
                  OP_FAST: dummy_n <= cfg_dummy;
                  OP_DUAL: begin dummy_n <= cfg_dummy; lane <= LANE_2; end
                  OP_QUAD: begin dummy_n <= cfg_dummy; lane <= LANE_4; end
                  OP_PP:   is_wr <= 1'b1;
                  OP_RDID: jedec <= 1'b1;
                  OP_EN4B: addr4_set_p <= 1'b1;
                  OP_EX4B: addr4_clr_p <= 1'b1;
                  default: ;
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (rise) begin
              addr_sh <= addr_full[30:0];
              bit_cnt <= bit_cnt + 6'd1;
              if (addr_last) begin
                bit_cnt   <= 6'd0;
                word_addr <= {addr_full[31:2], 2'b00};
                bptr      <= addr_full[1:0];
                // Programs merge into a fresh word, so only reads fetch.
                if (!is_wr) begin
                  mem_ren  <= 1'b1;
                  mem_addr <= {addr_full[31:2], 2'b00};
                  ren_cur  <= 1'b1;
                end
              end
            end
          end
          ST_DUMMY: begin
            if (rise) bit_cnt <= bit_cnt + 6'd1;
          end
          ST_RDATA: begin
            if (fall) begin
              dq_oe <= lane_oe(lane);
              dq_o  <= lane_bits;
              // Fetch the following word as soon as the last byte of this one starts.
              if (!jedec && pos == 3'd0 && bptr == 2'd3) begin
                mem_ren   <= 1'b1;
                mem_addr  <= word_addr + 32'd4;
                word_addr <= word_addr + 32'd4;
                ren_nxt   <= 1'b1;
              end
              if (byte_end) begin
                pos <= 3'd0;
                if (jedec) begin
                  jidx <= (jidx == 2'd2) ? 2'd0 : jidx + 2'd1;
                end else begin
                  bptr <= bptr + 2'd1;
                  if (bptr == 2'd3) cur_word <= next_word;
                end
              end else begin
                pos <= pos + step;
              end
            end
          end
          ST_WDATA: begin
            if (rise) begin
              sh      <= cmd_byte[6:0];
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd7) begin
                bit_cnt <= 6'd0;
                bptr    <= bptr + 2'd1;
                if (bptr == 2'd3) begin
                  mem_we    <= 1'b1;
                  mem_wdata <= wr_word_nx;
                  mem_wstrb <= wr_strb_nx;
                  mem_addr  <= word_addr;
                  word_addr <= word_addr + 32'd4;
                  wr_word   <= 32'h0;
                  wr_strb   <= 4'h0;
                end else begin
                  wr_word <= wr_word_nx;
                  wr_strb <= wr_strb_nx;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_fl.sv
module tb_spi_slave_fl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b1;
  logic        ss_n = 1'b1;
  logic [3:0]  dq_i = 4'h0;
  logic [3:0]  dq_o, dq_oe;
  logic [3:0]  cfg_dummy = 4'h0;
  logic [31:0] mem_addr;
  logic        mem_ren;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_slave_fl dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .ss_n     (ss_n),
    .dq_i     (dq_i),
    .dq_o     (dq_o),
    .dq_oe    (dq_oe),
    .cfg_dummy(cfg_dummy),
    .mem_addr (mem_addr),
    .mem_ren  (mem_ren),
    .mem_rdata(mem_rdata),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .busy     (busy)
  );

  // 1-clk latency RAM model.
  logic [31:0] ram [logic [31:0]];
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
  end

  // Scoreboard queues.
  logic [31:0] exp_rd[$];
  logic [67:0] exp_wr[$];   // {addr, wdata, wstrb}
  logic [11:0] exp_rx[$];   // {oe, byte}
  logic [11:0] got_rx[$];

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [67:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or a received byte.
  always @(negedge clk) begin
    if (mem_ren && mem_we) unexpected("ren_we_same_clk", {mem_addr, mem_wdata, mem_wstrb});
    if (mem_ren) begin
      if (exp_rd.size() == 0) unexpected("mem_ren", {36'h0, mem_addr});
      else chk("mem_ren_addr", {36'h0, mem_addr}, {36'h0, exp_rd.pop_front()});
    end
    if (mem_we) begin
      if (exp_wr.size() == 0) unexpected("mem_we", {mem_addr, mem_wdata, mem_wstrb});
      else chk("mem_we_addr_data_strb", {mem_addr, mem_wdata, mem_wstrb}, exp_wr.pop_front());
    end
    if (got_rx.size() != 0) begin
      if (exp_rx.size() == 0) unexpected("rx_byte", {56'h0, got_rx.pop_front()});
      else chk("rx_oe_byte", {56'h0, got_rx.pop_front()}, {56'h0, exp_rx.pop_front()});
    end
  end

  // SPI master (mode 3), half period 4 clk, all driven on negedge.
  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sclk = 1'b0; dq_i[0] = b; half();
    sclk = 1'b1; half();
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic recv_byte(input int lanes);
    logic [7:0] b;
    logic [3:0] oe;
    b = 8'h0; oe = 4'h0;
    for (int k = 0; k < 8 / lanes; k++) begin
      sclk = 1'b0; half();
      oe = dq_oe;
      case (lanes)
        1:       b = {b[6:0], dq_o[1]};
        2:       b = {b[5:0], dq_o[1:0]};
        default: b = {b[3:0], dq_o};
      endcase
      sclk = 1'b1; half();
    end
    got_rx.push_back({oe, b});
  endtask

  task automatic begin_frame();
    ss_n = 1'b0; half();
  endtask

  task automatic end_frame();
    half(); ss_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic rd_frame(input logic [7:0] cmd, input logic [31:0] addr, input int abits,
                          input int dummy, input int lanes, input int nbytes);
    begin_frame();
    send_bits({24'h0, cmd}, 8);
    if (abits > 0) send_bits(addr, abits);
    repeat (dummy) send_bit(1'b0);
    repeat (nbytes) recv_byte(lanes);
    end_frame();
  endtask

  task automatic exp_bytes(input logic [3:0] oe, input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) exp_rx.push_back({oe, v[8*(n-1-i) +: 8]});
  endtask

  initial begin
    ram[32'h0000_0010] = 32'h4433_2211;
    ram[32'h0000_0014] = 32'h8877_6655;
    ram[32'h0000_0100] = 32'hA3A2_A1A0;
    ram[32'h0000_0104] = 32'hB3B2_B1B0;
    ram[32'h0000_0108] = 32'hC3C2_C1C0;
    ram[32'h0100_0000] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    chk("rst_dq_oe", {64'h0, dq_oe}, 68'h0);
    chk("rst_dq_o", {64'h0, dq_o}, 68'h0);
    chk("rst_busy", {67'h0, busy}, 68'h0);
    chk("rst_mem_ren", {67'h0, mem_ren}, 68'h0);
    chk("rst_mem_we", {67'h0, mem_we}, 68'h0);
    chk("rst_mem_addr", {36'h0, mem_addr}, 68'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // READ 0x03 @0x10, 4 bytes; byte 3 start prefetches 0x14.
    exp_rd.push_back(32'h10); exp_rd.push_back(32'h14);
    exp_bytes(4'b0010, 64'h11223344, 4);
    rd_frame(8'h03, 32'h10, 24, 0, 1, 4);

    // FAST READ with zero dummies from 0x13: first byte is byte 3, prefetch right away.
    cfg_dummy = 4'd0;
    exp_rd.push_back(32'h10); exp_rd.push_back(32'h14);
    exp_bytes(4'b0010, 64'h445566, 3);
    rd_frame(8'h0B, 32'h13, 24, 0, 1, 3);

    // Quad read 0x6B @0x102, 8 dummies, 8 bytes, two prefetches.
    cfg_dummy = 4'd8;
    exp_rd.push_back(32'h100); exp_rd.push_back(32'h104); exp_rd.push_back(32'h108);
    exp_bytes(4'b1111, 64'hA2A3_B0B1_B2B3_C0C1, 8);
    rd_frame(8'h6B, 32'h102, 24, 8, 4, 8);

    // Dual read 0x3B @0x104, 4 dummies.
    cfg_dummy = 4'd4;
    exp_rd.push_back(32'h104);
    exp_bytes(4'b0011, 64'hB0B1, 2);
    rd_frame(8'h3B, 32'h104, 24, 4, 2, 2);

    // Page program @0x21: AA BB, partial word flushed at deselect.
    exp_wr.push_back({32'h20, 32'h00BB_AA00, 4'b0110});
    begin_frame();
    send_bits(32'h02, 8); send_bits(32'h21, 24);
    send_bits(32'hAA, 8); send_bits(32'hBB, 8);
    end_frame();

    // Page program @0x3E crossing a word: full write then partial flush.
    exp_wr.push_back({32'h3C, 32'h2211_0000, 4'b1100});
    exp_wr.push_back({32'h40, 32'h0000_4433, 4'b0011});
    begin_frame();
    send_bits(32'h02, 8); send_bits(32'h3E, 24);
    send_bits(32'h11, 8); send_bits(32'h22, 8); send_bits(32'h33, 8); send_bits(32'h44, 8);
    end_frame();

    // JEDEC id repeats.
    exp_bytes(4'b0010, 64'hEF4018_EF4018, 6);
    rd_frame(8'h9F, 32'h0, 0, 0, 1, 6);

    // 4-byte addressing on, read 0x01000000, then back off.
    rd_frame(8'hB7, 32'h0, 0, 0, 1, 0);
    exp_rd.push_back(32'h0100_0000); exp_rd.push_back(32'h0100_0004);
    exp_bytes(4'b0010, 64'hEFBEADDE, 4);
    rd_frame(8'h03, 32'h0100_0000, 32, 0, 1, 4);
    rd_frame(8'hE9, 32'h0, 0, 0, 1, 0);
    exp_rd.push_back(32'h10);
    exp_bytes(4'b0010, 64'h11, 1);
    rd_frame(8'h03, 32'h10, 24, 0, 1, 1);

    // Unknown opcode: no drive, no strobes.
    exp_bytes(4'b0000, 64'h0000, 2);
    rd_frame(8'h5A, 32'h0, 0, 0, 1, 2);

    // Abort mid-RDATA byte.
    exp_rd.push_back(32'h10);
    exp_bytes(4'b0010, 64'h11, 1);
    begin_frame();
    send_bits(32'h03, 8); send_bits(32'h10, 24);
    recv_byte(1);
    repeat (3) begin sclk = 1'b0; half(); sclk = 1'b1; half(); end
    chk("abort_oe_driving", {64'h0, dq_oe}, {64'h0, 4'b0010});
    ss_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_oe_off", {64'h0, dq_oe}, 68'h0);
    chk("abort_busy", {67'h0, busy}, 68'h0);
    repeat (12) @(negedge clk);

    // Reset mid-WDATA: no write ever issued.
    begin_frame();
    send_bits(32'h02, 8); send_bits(32'h50, 24);
    send_bits(32'h77, 8); send_bits(32'hF, 4);
    chk("wr_busy", {67'h0, busy}, 68'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", {67'h0, busy}, 68'h0);
    chk("rst_mid_oe", {64'h0, dq_oe}, 68'h0);
    chk("rst_mid_we", {67'h0, mem_we}, 68'h0);
    ss_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    chk("left_exp_rd", {36'h0, 32'(exp_rd.size())}, 68'h0);
    chk("left_exp_wr", {36'h0, 32'(exp_wr.size())}, 68'h0);
    chk("left_exp_rx", {36'h0, 32'(exp_rx.size())}, 68'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
